// File: rtl/apb_bus_arbiter_pkg.sv
// Shared types and helpers for the APB bus arbiter (apb_bus_arbiter, rr_pick).
package apb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 16;

    // $clog2 clamped to at least one bit so a binary index never collapses to zero width.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/apb_bus_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first asserted req searching upward from ptr, wrapping.
module rr_pick
    import apb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] pick_id,
    output logic          any
);

    // Offset k walks the rotation order; j is the physical slot that sits at that offset.
    always_comb begin
        pick    = {N{1'b0}};
        pick_id = {PW{1'b0}};
        any     = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && req[j] && (j == ((int'(ptr) + k) % N))) begin
                    pick[j] = 1'b1;
                    pick_id = PW'(j);
                    any     = 1'b1;
                end else begin
                    any = any;
                end
            end
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Round-robin / lockable arbiter for the bridge's single APB master port.
// Define APB_ARB_WRR_EN to add per-requester weights and a credit counter.
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int WEIGHT_W = 4,
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
`ifdef APB_ARB_WRR_EN
    input  logic [NUM_REQ*WEIGHT_W-1:0] weight,
`endif
    input  logic                        xfer_done,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        gnt_valid,
    output logic [ID_W-1:0]             gnt_id
);

    arb_state_e          state_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic                gnt_valid_r;
    logic [ID_W-1:0]     gnt_id_r;
    logic [ID_W-1:0]     ptr_r;
    logic [NUM_REQ-1:0]  pick_s;
    logic [ID_W-1:0]     pick_id_s;
    logic                any_s;
    logic                owner_lock_s;
    logic                owner_req_s;
    logic [ID_W-1:0]     ptr_next_s;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_r),
        .pick    (pick_s),
        .pick_id (pick_id_s),
        .any     (any_s)
    );

    // gnt_r is one-hot on the owner, so masking avoids a variable-width bit select.
    assign owner_lock_s = |(lock & gnt_r);
    assign owner_req_s  = |(req & gnt_r);
    assign ptr_next_s   = (gnt_id_r == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (gnt_id_r + ID_W'(1));

`ifdef APB_ARB_WRR_EN
    logic [WEIGHT_W-1:0] credit_r;
    logic [WEIGHT_W-1:0] pick_wt_s;

    // Weight of the requester about to be granted; zero is promoted to one.
    always_comb begin
        pick_wt_s = WEIGHT_W'(1);
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_s[j] && (weight[j*WEIGHT_W +: WEIGHT_W] != {WEIGHT_W{1'b0}})) begin
                pick_wt_s = weight[j*WEIGHT_W +: WEIGHT_W];
            end else begin
                pick_wt_s = pick_wt_s;
            end
        end
    end
`endif

    // Arbitration FSM: grant from IDLE, hold in OWN until a releasing xfer_done.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= IDLE;
            gnt_r       <= {NUM_REQ{1'b0}};
            gnt_valid_r <= 1'b0;
            gnt_id_r    <= {ID_W{1'b0}};
            ptr_r       <= {ID_W{1'b0}};
`ifdef APB_ARB_WRR_EN
            credit_r    <= {WEIGHT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        state_r     <= OWN;
                        gnt_r       <= pick_s;
                        gnt_valid_r <= 1'b1;
                        gnt_id_r    <= pick_id_s;
`ifdef APB_ARB_WRR_EN
                        credit_r    <= pick_wt_s;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                OWN: begin
                    if (!xfer_done || owner_lock_s) begin
                        state_r <= OWN;
`ifdef APB_ARB_WRR_EN
                    end else if (owner_req_s && (credit_r > WEIGHT_W'(1))) begin
                        credit_r <= credit_r - WEIGHT_W'(1);
`else
                    end else if (owner_req_s && 1'b0) begin
                        state_r <= OWN;
`endif
                    end else begin
                        state_r     <= IDLE;
                        gnt_r       <= {NUM_REQ{1'b0}};
                        gnt_valid_r <= 1'b0;
                        ptr_r       <= ptr_next_s;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    gnt_r       <= {NUM_REQ{1'b0}};
                    gnt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_id    = gnt_id_r;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Scoreboard bench for apb_bus_arbiter: directed scenarios plus random traffic against a reference model.
module tb_apb_bus_arbiter;
    import apb_arb_pkg::*;

    localparam int N  = 2;
    localparam int WW = 4;
    localparam int IW = 1;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [N-1:0]  req;
    logic [N-1:0]  lock;
    logic [N*WW-1:0] weight;
    logic          xfer_done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;

    apb_bus_arbiter #(.NUM_REQ(N), .WEIGHT_W(WW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (req),
        .lock      (lock),
`ifdef APB_ARB_WRR_EN
        .weight    (weight),
`endif
        .xfer_done (xfer_done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [N-1:0]  gnt;
        logic          vld;
        logic [IW-1:0] id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   owners_q[$];
    logic prev_vld = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: owner (-1 when idle), rotation pointer, remaining credit, last owner.
    int m_owner, m_ptr, m_credit, m_last, m_age;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endfunction

    function automatic void m_reset();
        m_owner = -1; m_ptr = 0; m_credit = 0; m_last = 0; m_age = 0;
    endfunction

    function automatic void m_step();
        int w;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && req[idx]) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_age   = 0;
`ifdef APB_ARB_WRR_EN
                    w = int'(weight[idx*WW +: WW]);
                    m_credit = (w == 0) ? 1 : w;
`else
                    w = 1;
                    m_credit = w;
`endif
                end
            end
        end else begin
            m_age++;
            if (xfer_done) begin
                m_age = 0;
                if (lock[m_owner]) begin
                    m_credit = m_credit;
                end else if (req[m_owner] && m_credit > 1) begin
                    m_credit--;
                end else begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    endfunction

    // One clock of stimulus: drive inputs, advance the model, queue what the DUT must show after the edge.
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic d);
        exp_t e;
        @(negedge HCLK);
        #1;
        req = r; lock = l; xfer_done = d;
        m_step();
        e.gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        e.vld = (m_owner >= 0);
        e.id  = IW'(m_last);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        #2;
        HRESETn = 1'b0; req = '0; lock = '0; xfer_done = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        m_reset();
        repeat (2) @(negedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    // Monitor: compare every queued expectation against the DUT, mid-cycle.
    always @(negedge HCLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("gnt", 32'(gnt), 32'(mon_e.gnt));
            chk("gnt_valid", 32'(gnt_valid), 32'(mon_e.vld));
            chk("gnt_id", 32'(gnt_id), 32'(mon_e.id));
        end
        if (gnt_valid && !prev_vld) owners_q.push_back(int'(gnt_id));
        prev_vld = gnt_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [N-1:0] r, l;
        HRESETn = 1'b0; req = '0; lock = '0; xfer_done = 1'b0;
        weight = {4'd1, 4'd3};
        #1;
        chk("init_gnt", 32'(gnt), 32'd0);
        chk("init_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("init_gnt_id", 32'(gnt_id), 32'd0);
        m_reset();
        repeat (2) @(negedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Single requester: req=01, one completion four cycles later.
        cyc(2'b00, 2'b00, 1'b0);
        for (int c = 0; c < 5; c++) cyc(2'b01, 2'b00, (c == 4));
        for (int c = 0; c < 3; c++) cyc(2'b00, 2'b00, 1'b0);

        // Lock: pointer now at 1; requester 1 holds the bus through four transfers.
        pulses = 0;
        for (int c = 0; c < 24; c++) begin
            l = (pulses < 3) ? 2'b10 : 2'b00;
            cyc(2'b11, l, (m_owner >= 0 && m_age == 2));
            if (xfer_done && m_owner == 1 && lock[1]) pulses++;
        end
        for (int c = 0; c < 6; c++) cyc(2'b00, 2'b00, (m_owner >= 0));

        // Fairness from a fresh pointer: owners must alternate 0,1,0,1.
        do_reset();
        owners_q.delete();
        for (int c = 0; c < 16; c++) cyc(2'b11, 2'b00, (m_owner >= 0 && m_age == 2));
        for (int c = 0; c < 6; c++) cyc(2'b00, 2'b00, (m_owner >= 0));
        @(negedge HCLK);
`ifndef APB_ARB_WRR_EN
        if (owners_q.size() < 4) begin
            chk("fair_count", 32'(owners_q.size()), 32'd4);
        end else begin
            for (int i = 0; i < 4; i++) chk("fair_owner", 32'(owners_q[i]), 32'(i % 2));
        end
`endif

`ifdef APB_ARB_WRR_EN
        weight = {4'd1, 4'd3};
        for (int c = 0; c < 30; c++) cyc(2'b11, 2'b00, (m_owner >= 0 && m_age == 1));
        weight = {4'd2, 4'd0};
        for (int c = 0; c < 30; c++) cyc(2'b11, 2'b00, (m_owner >= 0 && m_age == 1));
        for (int c = 0; c < 8; c++) cyc(2'b00, 2'b00, (m_owner >= 0));
`endif

        // Random traffic; the owner mostly keeps its request up.
        for (int c = 0; c < 400; c++) begin
            r = N'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
            l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            weight = (N*WW)'($urandom);
            cyc(r, l, ($urandom_range(0, 2) == 0));
        end

        // Reset while requester 1 owns the bus, then a fresh request from 1.
        for (int c = 0; c < 6; c++) cyc(2'b00, 2'b00, (m_owner >= 0));
        cyc(2'b10, 2'b00, 1'b0);
        cyc(2'b10, 2'b00, 1'b0);
        do_reset();
        cyc(2'b00, 2'b00, 1'b0);
        for (int c = 0; c < 3; c++) cyc(2'b10, 2'b00, 1'b0);

        for (int c = 0; c < 4 && exp_q.size() > 0; c++) @(posedge HCLK);
        @(negedge HCLK);
        #1;
        if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_bus_arbiter.md
# apb_bus_arbiter

Registered request/grant arbiter that shares the single APB master port of the AHB-to-APB bridge between `NUM_REQ` AHB slave-side requesters. It sits between the per-AHB-port front ends (request = decoded, valid, HSEL'd transfer) and the APB sequencer, which reports completion with `xfer_done`. It provides rotating-priority round-robin, optional weighted round-robin, and HMASTLOCK-style locked sequences.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range is 2..16.
- `WEIGHT_W`, 4: width of each per-requester weight/credit field.
- `HCLK` in 1: the only clock. All state updates on the rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: per-requester level request. Held high until its transfer completes.
- `lock` in `NUM_REQ`: per-requester lock (HMASTLOCK). Sampled on the `xfer_done` cycle.
- `weight` in `NUM_REQ*WEIGHT_W`: requester i uses bits [i*WEIGHT_W +: WEIGHT_W]. Present only with `APB_ARB_WRR_EN`.
- `xfer_done` in 1: single-cycle pulse from the APB sequencer when the current APB access ends (PENABLE & PREADY).
- `gnt` out `NUM_REQ`: one-hot grant, registered.
- `gnt_valid` out 1: equals |gnt.
- `gnt_id` out `$clog2(NUM_REQ)`: binary index of the owner. Holds the last owner when `gnt_valid`=0.

## Operation
- State `IDLE`:
  - If any `req` is high, pick the first asserted requester searching upward from `ptr`, wrapping modulo `NUM_REQ`.
  - Load the owner, set `gnt`, load `credit`, and go to `OWN`.
  - If no `req` is high, stay in `IDLE`.
- State `OWN`: `gnt` is held constant until `xfer_done`. `req`/`lock` changes of the owner without `xfer_done` are ignored. `xfer_done` in `IDLE` is ignored.
- On `xfer_done` in `OWN`, in priority order:
  1. `lock[owner]`=1: stay in `OWN`, same owner, `credit` unchanged.
  2. `req[owner]`=1 and `credit`>1: stay in `OWN`, same owner, `credit`--.
  3. Otherwise: go to `IDLE`, clear `gnt`, set `ptr`=(owner+1) mod `NUM_REQ`.
- `credit` is loaded with the owner's weight; a weight of 0 is treated as 1. Without WRR, `credit` is fixed at 1.
- Lock has priority over fairness. A locked owner is never pre-empted.
- Requests from non-owners are never lost; they stay pending as levels.

## Timing
- Reset values: `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `ptr`=0, `credit`=0, state `IDLE`.
- Grant latency: `req` first high in cycle N while in `IDLE` → `gnt` high in N+1.
- Release: `xfer_done` at cycle M (case 3) → `gnt`=0 at M+1. The next grant is at M+2 at the earliest, so there is always one idle cycle between different owners.
- Locked or credit continuation: no gap; `gnt` stays high across `xfer_done`.
- `ptr` wrap: an owner of `NUM_REQ`-1 gives `ptr`=0.
- Simultaneous `req` assertion: resolved purely by `ptr` order.
- `HRESETn` low at any time, including mid-`OWN`: all outputs go to their reset values immediately and asynchronously. The pending transfer is abandoned.

## Configuration
- `APB_ARB_WRR_EN` defined:
  - `weight` port present.
  - Credit counter of `WEIGHT_W` bits.
  - Continuation rule 2 is active.
- `APB_ARB_WRR_EN` undefined:
  - `weight` port absent.
  - No credit register.
  - Every non-locked `xfer_done` releases the grant, giving plain round-robin.

## Structure
- Shared package `apb_arb_pkg` contains:
  - state enum `arb_state_e` {IDLE, OWN};
  - `MAX_REQ`=16;
  - a function returning `$clog2` with a minimum of 1.
- One sub-module, `rr_pick`: a combinational rotating-priority one-hot picker. Inputs are `req` and `ptr`; outputs are one-hot `pick`, binary `pick_id`, and `any`.

## Test plan
- Single requester:
  - Stimulus: `req`=01 from cycle 2; `xfer_done` at cycle 6.
  - Required: `gnt`=01 at cycle 3; `gnt`=00 at cycle 7; `gnt_id`=0 throughout.
- Fairness, WRR off:
  - Stimulus: `req`=11 held; `xfer_done` 2 cycles after each grant.
  - Required: owner sequence 0,1,0,1, with exactly one `gnt`=00 cycle between owners.
- Lock:
  - Stimulus: `req`=11, `ptr`=1, `lock[1]`=1 for the first three `xfer_done` pulses, then 0.
  - Required: `gnt`=10 continuously through four transfers, then `gnt`=01.
- WRR, with `APB_ARB_WRR_EN`:
  - Stimulus: weights {3,1} (w0=3, w1=1); `req`=11 held.
  - Required: owner pattern 0,0,0,1 repeating. No gap within requester 0's three transfers.
- Zero weight:
  - Stimulus: w0=0, w1=2.
  - Required: pattern 0,1,1 repeating.
- Reset mid-operation:
  - Stimulus: `HRESETn` low while `gnt`=10; release; then `req`=10.
  - Required: `gnt`=00 in the same time step as reset. After release, `gnt`=10 one cycle after `req`, with `ptr` restarted at 0.
